// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Optional feature macro: DM_ARB_RR_EN (round-robin on conflict; undefined = core priority).
package dm_arb_pkg;

  // Arbiter FSM: idle, one memory access cycle, one response cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Requester indices; also the bit positions in the packed request/grant vectors.
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  // One-hot vector for a requester index.
  function automatic logic [1:0] onehot(input logic idx);
    return (idx == REQ_HOST) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner selection between the core and host requesters.
// Optional feature macro: DM_ARB_RR_EN selects round-robin on conflict;
// otherwise the core always wins a conflict.
module dm_arb_pick
  import dm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       valid,
  output logic       winner
);

`ifdef DM_ARB_RR_EN
  // Lone requester wins at once; on a conflict the one that did not win last time goes.
  always_comb begin
    // NOTE: default every output first so no path through the block leaves it unassigned (no latch).
    valid  = |req;
    winner = REQ_CORE;
    if (req == 2'b11) begin
      winner = ~last_owner;
    end else if (req[1]) begin
      winner = REQ_HOST;
    end
  end
`else
  // Fixed priority: the host wins only when the core is not requesting.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    valid  = |req;
    winner = REQ_CORE;
    if (!req[0] && req[1]) begin
      winner = REQ_HOST;
    end
  end
`endif

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares a single-port synchronous-read data memory between the CPU
// load/store path (core) and a host/loader port. One access at a time:
// IDLE/RESP arbitrate, ACCESS drives the memory, RESP returns Done and Rdata.
// Optional feature macro: DM_ARB_RR_EN (round-robin instead of core priority).
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  // core requester
  input  logic          CoreReq,
  input  logic          CoreWe,
  input  logic [AW-1:0] CoreAddr,
  input  logic [DW-1:0] CoreWdata,
  output logic          CoreGnt,
  output logic          CoreDone,
  // host requester
  input  logic          HostReq,
  input  logic          HostWe,
  input  logic [AW-1:0] HostAddr,
  input  logic [DW-1:0] HostWdata,
  output logic          HostGnt,
  output logic          HostDone,
  // response data, qualified by the owner's Done on a read
  output logic [DW-1:0] Rdata,
  // memory side
  output logic          MemEn,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWdata,
  input  logic [DW-1:0] MemRdata,
  output logic          Busy
);

  state_t        state_q;
  logic          owner_q;
  logic          last_owner_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [1:0]    gnt_q;
  logic [1:0]    done_q;

  logic [1:0]    req;
  logic          pick_valid;
  logic          pick_winner;

  assign req = {HostReq, CoreReq};

  dm_arb_pick u_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // FSM, winner capture and registered Gnt/Done pulses.
  always_ff @(posedge Clk) begin
    // NOTE: synchronous reset - only sampled on the clock edge, so it sits inside the clocked branch.
    if (Reset) begin
      state_q      <= IDLE;
      owner_q      <= REQ_CORE;
      last_owner_q <= REQ_HOST;   // core wins the first conflict
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop sees pre-edge values.
      gnt_q  <= '0;
      done_q <= '0;
      unique case (state_q)
        IDLE, RESP: begin
          if (pick_valid) begin
            state_q <= ACCESS;
            owner_q <= pick_winner;
            gnt_q   <= onehot(pick_winner);
            if (pick_winner == REQ_HOST) begin
              we_q    <= HostWe;
              addr_q  <= HostAddr;
              wdata_q <= HostWdata;
            end else begin
              we_q    <= CoreWe;
              addr_q  <= CoreAddr;
              wdata_q <= CoreWdata;
            end
            // Only contested grants move the round-robin pointer; a lone
            // requester does not disturb whose turn the next conflict is.
            if (req == 2'b11) begin
              last_owner_q <= pick_winner;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          state_q <= RESP;
          done_q  <= onehot(owner_q);
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Requester-side outputs: pulses come straight from registers.
  assign CoreGnt  = gnt_q[REQ_CORE];
  assign HostGnt  = gnt_q[REQ_HOST];
  assign CoreDone = done_q[REQ_CORE];
  assign HostDone = done_q[REQ_HOST];
  assign Busy     = (state_q != IDLE);

  // Memory-side outputs. The write enable is gated by Reset directly so an
  // access interrupted by reset never commits its write.
  assign MemEn    = (state_q == ACCESS);
  assign MemWe    = MemEn & we_q & ~Reset;
  assign MemAddr  = addr_q;
  assign MemWdata = wdata_q;

  // Synchronous-read data arrives in the RESP cycle; pass it through only then.
  assign Rdata    = (state_q == RESP) ? MemRdata : '0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter with a behavioural 256x8
// synchronous-read memory. Stimulus pushes expected responses into per-requester
// queues; a monitor pops and compares on every Done.
module tb_dm_port_arbiter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       CoreReq, CoreWe, HostReq, HostWe;
  logic [7:0] CoreAddr, CoreWdata, HostAddr, HostWdata;
  logic       CoreGnt, CoreDone, HostGnt, HostDone;
  logic [7:0] Rdata;
  logic       MemEn, MemWe;
  logic [7:0] MemAddr, MemWdata;
  logic [7:0] MemRdata;
  logic       Busy;

  always #5 Clk = ~Clk;

  dm_port_arbiter #(.AW(8), .DW(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .CoreReq(CoreReq), .CoreWe(CoreWe), .CoreAddr(CoreAddr), .CoreWdata(CoreWdata),
    .CoreGnt(CoreGnt), .CoreDone(CoreDone),
    .HostReq(HostReq), .HostWe(HostWe), .HostAddr(HostAddr), .HostWdata(HostWdata),
    .HostGnt(HostGnt), .HostDone(HostDone),
    .Rdata(Rdata),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemRdata(MemRdata), .Busy(Busy)
  );

  // Behavioural data memory: write-on-enable, registered read.
  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    MemRdata = 8'h00;
  end
  always @(posedge Clk) begin
    if (MemEn === 1'b1) begin
      if (MemWe === 1'b1) mem[MemAddr] <= MemWdata;
      MemRdata <= mem[MemAddr];
    end
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] rdata;
  } exp_t;

  exp_t core_q[$];
  exp_t host_q[$];
  exp_t core_e, host_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge Clk) if (MemWe === 1'b1) we_cnt++;

  // Monitor: pops the owner's queue on every Done.
  always @(negedge Clk) begin
    if (Reset === 1'b0) begin
      if (CoreGnt === 1'b1 || HostGnt === 1'b1) check("gnt_exclusive", CoreGnt & HostGnt, 0);
      if (CoreDone === 1'b1 || HostDone === 1'b1) check("done_exclusive", CoreDone & HostDone, 0);
      if (CoreDone === 1'b1) begin
        if (core_q.size() == 0) check("core_unexpected_done", 1, 0);
        else begin
          core_e = core_q.pop_front();
          if (!core_e.we) check("core_rdata", Rdata, core_e.rdata);
          else            check("core_wr_resp_memwe", MemWe, 0);
        end
      end
      if (HostDone === 1'b1) begin
        if (host_q.size() == 0) check("host_unexpected_done", 1, 0);
        else begin
          host_e = host_q.pop_front();
          if (!host_e.we) check("host_rdata", Rdata, host_e.rdata);
          else            check("host_wr_resp_memwe", MemWe, 0);
        end
      end
    end
  end

  // One access by requester `who` (0=core, 1=host). Call between clock edges;
  // returns at the negedge of the Done cycle. exp_dly = cycles from request to Gnt.
  task automatic access(input logic who, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] rdata,
                        input int exp_dly, output int gcyc);
    int    start;
    bit    got;
    string tag;
    tag = who ? "host" : "core";
    if (who) begin
      HostReq = 1'b1; HostWe = we; HostAddr = addr; HostWdata = wdata;
      host_q.push_back('{we, addr, rdata});
    end else begin
      CoreReq = 1'b1; CoreWe = we; CoreAddr = addr; CoreWdata = wdata;
      core_q.push_back('{we, addr, rdata});
    end
    start = cyc;
    got   = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clk);
      if ((who ? HostGnt : CoreGnt) === 1'b1) got = 1'b1;
    end
    gcyc = cyc;
    if (!got) begin
      check({tag, "_gnt_timeout"}, 0, 1);
      if (who) begin HostReq = 1'b0; void'(host_q.pop_back()); end
      else     begin CoreReq = 1'b0; void'(core_q.pop_back()); end
      return;
    end
    check({tag, "_gnt_latency"}, cyc - start, exp_dly);
    check({tag, "_access_memwe"}, MemWe, we);
    check({tag, "_access_memaddr"}, MemAddr, addr);
    @(posedge Clk); #1;
    if (who) HostReq = 1'b0; else CoreReq = 1'b0;
    @(negedge Clk);
    check({tag, "_done_latency"}, who ? HostDone : CoreDone, 1);
  endtask

  logic [7:0] pre_addr [6] = '{8'h05, 8'h06, 8'h00, 8'h02, 8'h03, 8'hFF};
  logic [7:0] pre_data [6] = '{8'h55, 8'h66, 8'h00, 8'hFF, 8'hFF, 8'h77};
  logic [7:0] burst_exp [4] = '{8'h00, 8'h03, 8'hFF, 8'hFF};

  initial begin
    int g0, g1, w0;
    int gc [4];
    Reset = 1'b1;
    CoreReq = 1'b0; CoreWe = 1'b0; CoreAddr = '0; CoreWdata = '0;
    HostReq = 1'b0; HostWe = 1'b0; HostAddr = '0; HostWdata = '0;

    // 1: reset held two cycles under random requests.
    repeat (2) begin
      @(posedge Clk); #1;
      CoreReq = 1'($urandom); CoreWe = 1'($urandom); CoreAddr = 8'($urandom);
      HostReq = 1'($urandom); HostWe = 1'($urandom); HostAddr = 8'($urandom);
      @(negedge Clk);
      check("rst_gnt",   {CoreGnt, HostGnt}, 0);
      check("rst_done",  {CoreDone, HostDone}, 0);
      check("rst_memen", MemEn, 0);
      check("rst_memwe", MemWe, 0);
      check("rst_busy",  Busy, 0);
      check("rst_rdata", Rdata, 0);
      check("rst_maddr", MemAddr, 0);
    end
    @(posedge Clk); #1;
    Reset = 1'b0; CoreReq = 1'b0; HostReq = 1'b0; CoreWe = 1'b0; HostWe = 1'b0;
    @(negedge Clk);
    check("idle_busy", Busy, 0);

    // 2: host write 0x03 -> 0x01, then read it back; MemWe high exactly one cycle.
    w0 = we_cnt;
    access(1'b1, 1'b1, 8'h01, 8'h03, 8'h00, 1, g0);
    check("host_wr_memwe_cycles", we_cnt - w0, 1);
    access(1'b1, 1'b0, 8'h01, 8'h00, 8'h03, 1, g0);

    // Preload operands used below.
    for (int i = 0; i < 6; i++) access(1'b1, 1'b1, pre_addr[i], pre_data[i], 8'h00, 1, g0);

    // 3: simultaneous reads; core wins the first conflict in both builds.
    fork
      access(1'b0, 1'b0, 8'h05, 8'h00, 8'h55, 1, g0);
      access(1'b1, 1'b0, 8'h06, 8'h00, 8'h66, 3, g1);
    join
    check("conflict1_gnt_gap", g1 - g0, 2);
`ifdef DM_ARB_RR_EN
    fork
      access(1'b0, 1'b0, 8'h06, 8'h00, 8'h66, 3, g0);
      access(1'b1, 1'b0, 8'h05, 8'h00, 8'h55, 1, g1);
    join
    check("conflict2_gnt_gap", g0 - g1, 2);
`else
    fork
      access(1'b0, 1'b0, 8'h06, 8'h00, 8'h66, 1, g0);
      access(1'b1, 1'b0, 8'h05, 8'h00, 8'h55, 3, g1);
    join
    check("conflict2_gnt_gap", g1 - g0, 2);
`endif

    // 4: core streams reads of 0x00..0x03 with Req held; one Gnt every 2 cycles.
    for (int i = 0; i < 4; i++) access(1'b0, 1'b0, 8'(i), 8'h00, burst_exp[i], 1, gc[i]);
    for (int i = 1; i < 4; i++) check("burst_gnt_spacing", gc[i] - gc[i-1], 2);

    // 5: host write of 0xAA to 0xFF abandoned by reset in its ACCESS cycle.
    HostReq = 1'b1; HostWe = 1'b1; HostAddr = 8'hFF; HostWdata = 8'hAA;
    @(negedge Clk);
    check("rstmid_gnt", HostGnt, 1);
    Reset = 1'b1;
    #1;
    check("rstmid_memwe", MemWe, 0);
    @(posedge Clk); #1;
    HostReq = 1'b0; HostWe = 1'b0; Reset = 1'b0;
    @(negedge Clk);
    check("rstmid_no_done", {CoreDone, HostDone}, 0);
    check("rstmid_no_gnt",  {CoreGnt, HostGnt}, 0);
    check("rstmid_busy",    Busy, 0);
    access(1'b1, 1'b0, 8'hFF, 8'h00, 8'h77, 1, g0);

    // 6: address extremes do not alias.
    access(1'b0, 1'b1, 8'hFF, 8'h5A, 8'h00, 1, g0);
    access(1'b1, 1'b1, 8'h00, 8'hA5, 8'h00, 1, g0);
    access(1'b0, 1'b0, 8'hFF, 8'h00, 8'h5A, 1, g0);
    access(1'b1, 1'b0, 8'h00, 8'h00, 8'hA5, 1, g0);

    repeat (4) @(negedge Clk);
    check("core_queue_drained", core_q.size(), 0);
    check("host_queue_drained", host_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
